// File: rtl/rle_word_decoder.sv
// Word-level RLE decoder: a header beat carries a repeat count, the next beat is the
// payload, which is replayed that many times on the send stream with full backpressure.
module rle_word_decoder #(
    parameter int DATA_BITS = 512,
    parameter int ID_BITS   = 6,
    parameter int CNT_BITS  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_BITS-1:0]   axis_host_recv_tdata,
    input  logic [DATA_BITS/8-1:0] axis_host_recv_tkeep,
    input  logic [ID_BITS-1:0]     axis_host_recv_tid,
    input  logic                   axis_host_recv_tlast,
    input  logic                   axis_host_recv_tvalid,
    output logic                   axis_host_recv_tready,
    output logic [DATA_BITS-1:0]   axis_host_send_tdata,
    output logic [DATA_BITS/8-1:0] axis_host_send_tkeep,
    output logic [ID_BITS-1:0]     axis_host_send_tid,
    output logic                   axis_host_send_tlast,
    output logic                   axis_host_send_tvalid,
    input  logic                   axis_host_send_tready,
    output logic                   busy,
    output logic [31:0]            tokens_done
);

    typedef enum logic [1:0] {S_HDR, S_PAY, S_EMIT} state_t;

    state_t              state, state_nxt;
    logic [CNT_BITS-1:0] cnt_q, rem_q;
    logic [ID_BITS-1:0]  tid_q;
    logic                last_flag, rdy_q;
    logic                recv_fire, send_fire, last_beat, token_end;

    assign recv_fire = axis_host_recv_tvalid && rdy_q;
    assign send_fire = axis_host_send_tvalid && axis_host_send_tready;
    assign last_beat = (rem_q == CNT_BITS'(1));

    assign axis_host_recv_tready = rdy_q;
    assign axis_host_send_tlast  = last_flag && last_beat;
    assign busy                  = (state != S_HDR);

    always_comb begin
        state_nxt = state;
        token_end = 1'b0;
        case (state)
            S_HDR:  if (recv_fire) state_nxt = S_PAY;
            S_PAY: begin
                if (recv_fire) begin
                    if (cnt_q == '0) begin
                        state_nxt = S_HDR;
                        token_end = 1'b1;
                    end else begin
                        state_nxt = S_EMIT;
                    end
                end
            end
            S_EMIT: begin
                if (send_fire && last_beat) begin
                    state_nxt = S_HDR;
                    token_end = 1'b1;
                end
            end
            default: state_nxt = S_HDR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                 <= S_HDR;
            rdy_q                 <= 1'b0;
            cnt_q                 <= '0;
            rem_q                 <= '0;
            tid_q                 <= '0;
            last_flag             <= 1'b0;
            axis_host_send_tvalid <= 1'b0;
            axis_host_send_tdata  <= '0;
            axis_host_send_tkeep  <= '0;
            axis_host_send_tid    <= '0;
            tokens_done           <= '0;
        end else begin
            state <= state_nxt;
            // ready is a pure function of the registered state, never of tvalid/tready
            rdy_q <= (state_nxt != S_EMIT);
            if (token_end)
                tokens_done <= tokens_done + 32'd1;
            case (state)
                S_HDR: begin
                    if (recv_fire) begin
                        cnt_q <= axis_host_recv_tdata[CNT_BITS-1:0];
                        tid_q <= axis_host_recv_tid;
                    end
                end
                S_PAY: begin
                    if (recv_fire && cnt_q != '0) begin
                        axis_host_send_tdata  <= axis_host_recv_tdata;
                        axis_host_send_tkeep  <= axis_host_recv_tkeep;
                        axis_host_send_tid    <= tid_q;
                        last_flag             <= axis_host_recv_tlast;
                        axis_host_send_tvalid <= 1'b1;
                        rem_q                 <= cnt_q;
                    end
                end
                S_EMIT: begin
                    if (send_fire) begin
                        rem_q <= rem_q - CNT_BITS'(1);
                        if (last_beat)
                            axis_host_send_tvalid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/rle_word_decoder.md
# rle_word_decoder

Decodes a run-length-encoded host stream. Each token is a header beat holding a repeat count, then one payload beat; the block emits the payload beat that many times on the send side. It sits on the AXI4SR host path between `axis_host_recv` and `axis_host_send`, as the decompression end for the word-level RLE encoder in the compression pipeline. Output is registered, and the block fully honours backpressure.

## Interface
- `DATA_BITS`, default 512: tdata width; tkeep is DATA_BITS/8.
- `ID_BITS`, default 6: tid width.
- `CNT_BITS`, default 32: repeat-count width, taken from header tdata[CNT_BITS-1:0]; must be ≤ DATA_BITS.
- `clk` in, 1: single clock, all logic on its rising edge.
- `rst` in, 1: reset, synchronous and active-high.
- `axis_host_recv` AXI4SR.s: encoded token stream in (tdata, tkeep, tid, tlast, tvalid, tready).
- `axis_host_send` AXI4SR.m: decoded stream out (same fields).
- `busy` out, 1: high whenever the FSM is not in S_HDR.
- `tokens_done` out, 32: count of completed tokens, including count-0 tokens; wraps 2^32-1 → 0.

## Operation
- FSM states: S_HDR, S_PAY, S_EMIT. Reset state is S_HDR.
- **S_HDR**
  - recv.tready=1.
  - On handshake: latch cnt=tdata[CNT_BITS-1:0] and tid.
  - Header tkeep and tlast are ignored.
  - Next state is S_PAY.
- **S_PAY**
  - recv.tready=1.
  - On handshake with cnt≠0:
    - Load the output register with payload tdata and tkeep, latched tid, and last_flag=payload tlast.
    - Set send.tvalid=1 and rem=cnt; go to S_EMIT.
  - On handshake with cnt=0:
    - Discard the payload, emitting nothing, even if tlast=1.
    - Increment tokens_done; go to S_HDR.
- **S_EMIT**
  - recv.tready=0.
  - Each send handshake decrements rem.
  - send.tlast = last_flag && (rem==1).
  - The handshake with rem==1 is the final one:
    - Clear send.tvalid next cycle.
    - Increment tokens_done; go to S_HDR.
  - tdata, tkeep and tid are held constant for the whole run.
- **Field handling**
  - Width: rem is CNT_BITS wide; the maximum run is 2^CNT_BITS-1 beats, with no overflow.
  - tid on every output beat equals the header beat's tid; the payload tid is ignored.
- **Reset**
  - Reset mid-operation, in any state, drops the token in progress and any pending output.
  - Output holds its reset values (see Timing) until the next header handshake.

## Timing
- **Reset values:**
  - send.tvalid=0, send.tlast=0, send.tdata=0, send.tkeep=0, send.tid=0.
  - recv.tready=0 during the reset cycle; it becomes 1 the cycle after rst deasserts.
  - busy=0, tokens_done=0, state=S_HDR.
- recv.tready is a registered/state decode only; it never depends combinationally on recv.tvalid or send.tready.
- **Latency:** payload handshake at cycle t → send.tvalid=1 at t+1.
- **Throughput:** N+2 cycles per token at no backpressure (header, payload, N output beats). The next header is accepted no earlier than the cycle after the final output handshake.
- **Backpressure:** while send.tvalid=1 and send.tready=0, every send field is stable.
- **Validity:** recv.tvalid deasserting mid-token simply stalls the FSM in S_HDR or S_PAY; no timeout.
- **tokens_done update:** takes effect the cycle after the completing handshake.

## Test plan
- **Single run:** header cnt=3, tid=5; payload tdata=0xA5 pattern, tkeep=all-ones, tlast=1; send.tready=1.
  - Expect 3 identical beats on consecutive cycles, starting the cycle after the payload handshake.
  - tid=5 on all 3; tlast only on beat 3.
  - tokens_done=1.
- **Backpressure:** cnt=4; send.tready toggles 1,0,0,1,0,1,1.
  - Expect exactly 4 beats, with data and tlast stable during stalls.
  - recv.tready=0 until the 4th handshake completes.
- **Zero count:** header cnt=0 with payload tlast=1, then header cnt=1 with payload 0x1234, tlast=0.
  - Expect 1 output beat only: 0x1234, tlast=0.
  - tokens_done=2.
- **Back-to-back tokens:** cnt=1, 2, 1 with payloads P0, P1, P2, recv.tvalid held high.
  - Expect output P0, P1, P1, P2, with no beat lost or duplicated.
  - recv.tready low exactly during S_EMIT.
- **Reset mid-run:** cnt=10; assert rst after the 4th output beat.
  - Expect send.tvalid=0 the next cycle and busy=0, tokens_done=0.
  - A new cnt=2 token then decodes correctly.
- **Counter wrap:** preload tokens_done to 0xFFFFFFFF via the bench force, then complete one token.
  - Expect tokens_done=0.
